// File: rtl/vad_pkg.sv
// Shared types and elaboration helpers for the voice-activity energy detector.
// Holds the VAD state encoding, a constant clog2 and the accumulator width check.
package vad_pkg;

    typedef enum logic [1:0] {
        WARMUP   = 2'd0,
        SILENCE  = 2'd1,
        SPEECH   = 2'd2,
        HANGOVER = 2'd3
    } vad_state_t;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((longint'(1) << r) < longint'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // |x| needs DATA_W+1 bits; a window of WINDOW of them needs clog2(WINDOW) more.
    function automatic int sum_w_min(input int data_w, input int window);
        return data_w + 1 + clog2(window);
    endfunction

    function automatic bit sum_w_ok(
        input int sum_w,
        input int data_w,
        input int window
    );
        return sum_w >= sum_w_min(data_w, window);
    endfunction

    localparam int DEFAULT_SUM_W_MIN = sum_w_min(16, 5000);

endpackage

// File: rtl/window_accumulator.sv
// Sliding-window sum of |x| over the last WINDOW accepted samples.
// Ports: clock, reset_n, sample_valid, data_in, data_delayed -> energy, energy_valid, upd.
module window_accumulator
    import vad_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int WINDOW = 5000,
    parameter int SUM_W  = 30
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_delayed,
    output logic [SUM_W-1:0]  energy,
    output logic              energy_valid,
    output logic              upd
);

    localparam int MAG_W  = DATA_W + 1;
    localparam int FILL_W = (clog2(WINDOW + 1) < 1) ? 1 : clog2(WINDOW + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WINDOW);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WINDOW - 1);

    logic [MAG_W-1:0]  mag_in;
    logic [MAG_W-1:0]  mag_delayed;
    logic [MAG_W-1:0]  mag_sub;
    logic [FILL_W-1:0] fill;
    logic              full;

    // One extra bit so that the most negative sample has an exact magnitude.
    function automatic logic [MAG_W-1:0] magnitude(input logic [DATA_W-1:0] x);
        logic [MAG_W-1:0] ext;
        ext = {x[DATA_W-1], x};
        return ext[MAG_W-1] ? (~ext + MAG_W'(1)) : ext;
    endfunction

    assign full        = (fill == FILL_MAX);
    assign mag_in      = magnitude(data_in);
    assign mag_delayed = magnitude(data_delayed);

    // The delay line holds garbage until it has seen WINDOW samples.
    assign mag_sub = full ? mag_delayed : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            energy       <= '0;
            energy_valid <= 1'b0;
            fill         <= '0;
            upd          <= 1'b0;
        end else begin
            upd <= sample_valid;
            if (sample_valid) begin
                energy <= energy + SUM_W'(mag_in) - SUM_W'(mag_sub);
                if (!full) begin
                    fill <= fill + FILL_W'(1);
                end
                if (fill == FILL_LAST) begin
                    energy_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vad_energy_detector.sv
// Voice-activity detector: window energy plus onset/hangover state machine.
// Ports: clock, reset_n, sample_valid, data_in, data_delayed, threshold,
// threshold_low -> energy, energy_valid, speech_active, speech_start, speech_end.
// Build option: define VAD_HYSTERESIS_EN to hold speech against threshold_low.
module vad_energy_detector
    import vad_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int WINDOW    = 5000,
    parameter int SUM_W     = 30,
    parameter int ONSET_CNT = 8,
    parameter int HANG_CNT  = 4000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_delayed,
    input  logic [SUM_W-1:0]  threshold,
    input  logic [SUM_W-1:0]  threshold_low,
    output logic [SUM_W-1:0]  energy,
    output logic              energy_valid,
    output logic              speech_active,
    output logic              speech_start,
    output logic              speech_end
);

    localparam int ONSET_W = (clog2(ONSET_CNT + 1) < 1) ? 1 : clog2(ONSET_CNT + 1);
    localparam int HANG_W  = (clog2(HANG_CNT + 1) < 1) ? 1 : clog2(HANG_CNT + 1);
    localparam logic [ONSET_W-1:0] ONSET_TOP = ONSET_W'(ONSET_CNT - 1);
    localparam logic [HANG_W-1:0]  HANG_TOP  = HANG_W'(HANG_CNT - 1);

    if (!sum_w_ok(SUM_W, DATA_W, WINDOW)) begin : g_sum_w_check
        $error("SUM_W too small for DATA_W and WINDOW");
    end

    if (ONSET_CNT < 1 || HANG_CNT < 2) begin : g_cnt_check
        $error("ONSET_CNT must be >= 1 and HANG_CNT >= 2");
    end

    logic               upd;
    logic               act;
    logic [SUM_W-1:0]   thr_hold;

    vad_state_t         state_q;
    vad_state_t         state_nx;
    logic [ONSET_W-1:0] onset_q;
    logic [ONSET_W-1:0] onset_nx;
    logic [HANG_W-1:0]  hang_q;
    logic [HANG_W-1:0]  hang_nx;

    logic               active_q;
    logic               active_nx;
    logic               start_q;
    logic               start_nx;
    logic               end_q;
    logic               end_nx;

`ifdef VAD_HYSTERESIS_EN
    assign thr_hold = threshold_low;
`else
    // threshold_low stays on the pin list for drop-in compatibility.
    logic unused_threshold_low;
    assign unused_threshold_low = ^threshold_low;
    assign thr_hold = threshold;
`endif

    window_accumulator #(
        .DATA_W (DATA_W),
        .WINDOW (WINDOW),
        .SUM_W  (SUM_W)
    ) u_acc (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .data_in      (data_in),
        .data_delayed (data_delayed),
        .energy       (energy),
        .energy_valid (energy_valid),
        .upd          (upd)
    );

    // Decisions are only taken on a freshly updated, fully warmed-up energy.
    assign act = upd & energy_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WARMUP;
            onset_q  <= '0;
            hang_q   <= '0;
            active_q <= 1'b0;
            start_q  <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_nx;
            onset_q  <= onset_nx;
            hang_q   <= hang_nx;
            active_q <= active_nx;
            start_q  <= start_nx;
            end_q    <= end_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        onset_nx = onset_q;
        hang_nx  = hang_q;
        if (act) begin
            unique case (state_q)
                WARMUP: begin
                    state_nx = SILENCE;
                end
                SILENCE: begin
                    if (energy > threshold) begin
                        if (onset_q == ONSET_TOP) begin
                            state_nx = SPEECH;
                            onset_nx = '0;
                        end else begin
                            onset_nx = onset_q + ONSET_W'(1);
                        end
                    end else begin
                        onset_nx = '0;
                    end
                end
                SPEECH: begin
                    if (energy <= thr_hold) begin
                        state_nx = HANGOVER;
                        hang_nx  = HANG_W'(1);
                    end
                end
                HANGOVER: begin
                    if (energy > thr_hold) begin
                        state_nx = SPEECH;
                        hang_nx  = '0;
                    end else if (hang_q == HANG_TOP) begin
                        state_nx = SILENCE;
                        hang_nx  = '0;
                    end else begin
                        hang_nx = hang_q + HANG_W'(1);
                    end
                end
            endcase
        end
    end

    // Pulses come from the transition itself, so re-entry into SPEECH
    // from HANGOVER never produces a start pulse.
    always_comb begin
        start_nx  = (state_q == SILENCE) && (state_nx == SPEECH);
        end_nx    = (state_q == HANGOVER) && (state_nx == SILENCE);
        active_nx = (state_nx == SPEECH) || (state_nx == HANGOVER);
    end

    assign speech_active = active_q;
    assign speech_start  = start_q;
    assign speech_end    = end_q;

endmodule

// File: tb/tb_vad_energy_detector.sv
// Scoreboard bench for vad_energy_detector with a small window.
// Driver pushes expected energy/FSM results; a negedge monitor pops and compares.
module tb_vad_energy_detector;

    localparam int DW   = 16;
    localparam int WIN  = 16;
    localparam int SW   = 24;
    localparam int ON   = 2;
    localparam int HANG = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_delayed = '0;
    logic [SW-1:0] threshold = '1;
    logic [SW-1:0] threshold_low = 24'd400;
    logic [SW-1:0] energy;
    logic          energy_valid;
    logic          speech_active;
    logic          speech_start;
    logic          speech_end;

    vad_energy_detector #(
        .DATA_W    (DW),
        .WINDOW    (WIN),
        .SUM_W     (SW),
        .ONSET_CNT (ON),
        .HANG_CNT  (HANG)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .sample_valid  (sample_valid),
        .data_in       (data_in),
        .data_delayed  (data_delayed),
        .threshold     (threshold),
        .threshold_low (threshold_low),
        .energy        (energy),
        .energy_valid  (energy_valid),
        .speech_active (speech_active),
        .speech_start  (speech_start),
        .speech_end    (speech_end)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [SW-1:0] e;
        logic          v;
    } e_exp_t;

    typedef struct packed {
        logic a;
        logic s;
        logic n;
    } f_exp_t;

    e_exp_t eq[$];
    f_exp_t fq[$];
    e_exp_t e_last = '0;
    f_exp_t f_last = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic sv_d1;
    logic sv_d2;

    // Reference model state.
    int   m_fill;
    int   m_energy;
    int   m_state;
    int   m_onset;
    int   m_hang;
    logic m_act;
    logic m_ss;
    logic m_se;
    logic signed [DW-1:0] hist[$];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    function automatic int absv(input logic signed [DW-1:0] v);
        return (v < 0) ? -int'(v) : int'(v);
    endfunction

    task automatic model_clear();
        m_fill   = 0;
        m_energy = 0;
        m_state  = 0;
        m_onset  = 0;
        m_hang   = 0;
        m_act    = 1'b0;
        m_ss     = 1'b0;
        m_se     = 1'b0;
        hist.delete();
        eq.delete();
        fq.delete();
        e_last = '0;
        f_last = '0;
    endtask

    // States: 0 warm-up, 1 silence, 2 speech, 3 hangover.
    task automatic fsm_step();
        int hold;
`ifdef VAD_HYSTERESIS_EN
        hold = int'(threshold_low);
`else
        hold = int'(threshold);
`endif
        m_ss = 1'b0;
        m_se = 1'b0;
        if (m_fill == WIN) begin
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                if (m_energy > int'(threshold)) begin
                    m_onset++;
                    if (m_onset == ON) begin
                        m_state = 2;
                        m_onset = 0;
                        m_ss    = 1'b1;
                    end
                end else begin
                    m_onset = 0;
                end
            end else if (m_state == 2) begin
                if (m_energy <= hold) begin
                    m_state = 3;
                    m_hang  = 1;
                end
            end else begin
                if (m_energy > hold) begin
                    m_state = 2;
                    m_hang  = 0;
                end else begin
                    m_hang++;
                    if (m_hang == HANG) begin
                        m_state = 1;
                        m_hang  = 0;
                        m_se    = 1'b1;
                    end
                end
            end
        end
        m_act = (m_state == 2) || (m_state == 3);
    endtask

    task automatic send(input int x);
        logic signed [DW-1:0] xs;
        logic signed [DW-1:0] dd;
        int sub;
        xs = DW'(x);
        if (hist.size() == WIN) dd = hist[0];
        else dd = DW'($urandom);
        sub = (m_fill == WIN) ? absv(dd) : 0;
        m_energy = m_energy + absv(xs) - sub;
        hist.push_back(xs);
        if (hist.size() > WIN) void'(hist.pop_front());
        if (m_fill < WIN) m_fill++;
        eq.push_back('{e: SW'(m_energy), v: (m_fill == WIN)});
        fsm_step();
        fq.push_back('{a: m_act, s: m_ss, n: m_se});
        sample_valid = 1'b1;
        data_in      = xs;
        data_delayed = dd;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Asserted mid-cycle, away from any clock edge.
    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_energy", 32'(energy), 32'd0);
        chk("rst_energy_valid", 32'(energy_valid), 32'd0);
        chk("rst_active", 32'(speech_active), 32'd0);
        chk("rst_start", 32'(speech_start), 32'd0);
        chk("rst_end", 32'(speech_end), 32'd0);
        model_clear();
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        idle(1);
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sv_d1 <= 1'b0;
            sv_d2 <= 1'b0;
        end else begin
            sv_d1 <= sample_valid;
            sv_d2 <= sv_d1;
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (sv_d1) begin
                if (eq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL energy_queue: got empty expected entry");
                end else begin
                    e_last = eq.pop_front();
                end
                chk("energy", 32'(energy), 32'(e_last.e));
                chk("energy_valid", 32'(energy_valid), 32'(e_last.v));
            end else begin
                chk("energy_hold", 32'(energy), 32'(e_last.e));
                chk("valid_hold", 32'(energy_valid), 32'(e_last.v));
            end
            if (sv_d2) begin
                if (fq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL fsm_queue: got empty expected entry");
                end else begin
                    f_last = fq.pop_front();
                end
                chk("speech_active", 32'(speech_active), 32'(f_last.a));
                chk("speech_start", 32'(speech_start), 32'(f_last.s));
                chk("speech_end", 32'(speech_end), 32'(f_last.n));
            end else begin
                chk("active_hold", 32'(speech_active), 32'(f_last.a));
                chk("start_idle", 32'(speech_start), 32'd0);
                chk("end_idle", 32'(speech_end), 32'd0);
            end
        end
    end

    initial begin
        model_clear();
        do_reset();

        // Constant 100: 1600 after the 16th strobe, then steady.
        repeat (20) send(100);
        idle(3);

        // Most negative sample: 524288 after 16 strobes, steady.
        do_reset();
        repeat (20) send(-32768);
        idle(3);

        // Onset then full hangover release.
        do_reset();
        threshold = 24'd1000;
        repeat (16) send(0);
        repeat (16) send(200);
        repeat (16) send(0);
        idle(3);

        // Burst on third hangover update returns to speech silently.
        repeat (16) send(200);
        repeat (12) send(0);
        send(1000);
        repeat (20) send(0);
        idle(3);

        // Energy settling at 600 between threshold_low and threshold.
        do_reset();
        threshold     = 24'd1000;
        threshold_low = 24'd400;
        repeat (16) send(0);
        repeat (16) send(100);
        repeat (4) begin
            send(100);
            send(-100);
            send(100);
            repeat (5) send(0);
        end
        idle(3);

        // Reset in the middle of speech, then a fresh warm-up.
        repeat (16) send(200);
        idle(2);
        do_reset();
        repeat (16) send(300);
        idle(3);

        chk("queues_drained", 32'(eq.size() + fq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vad_energy_detector.md
Name: vad_energy_detector

Overview:
Downstream consumer of the 16-bit sample delay line in the speech front end. Takes each new audio sample plus the same-stream sample delayed by WINDOW samples. Maintains a running sliding-window sum of absolute amplitude (short-term energy) and drives a voice-activity state machine with onset qualification and hangover. Its output gates the downstream feature-extraction stage.

Parameters:
DATA_W, 16, sample width (signed two's complement)
WINDOW, 5000, window length in samples; must equal the upstream delay-line depth
SUM_W, 30, accumulator width; elaboration error if < DATA_W+1+clog2(WINDOW)
ONSET_CNT, 8, consecutive above-threshold updates required to declare speech
HANG_CNT, 4000, consecutive below-threshold updates before speech is released

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
sample_valid  in  1  one-cycle strobe; data_in/data_delayed are valid
data_in  in  DATA_W  newest sample, signed
data_delayed  in  DATA_W  sample accepted WINDOW strobes earlier, signed
threshold  in  SUM_W  speech-on energy threshold, unsigned, sampled every update
threshold_low  in  SUM_W  speech-hold threshold; used only with VAD_HYSTERESIS_EN
energy  out  SUM_W  current window sum of |x|
energy_valid  out  1  high once window is full; stays high until reset
speech_active  out  1  high in SPEECH and HANGOVER
speech_start  out  1  one-cycle pulse on SILENCE->SPEECH
speech_end  out  1  one-cycle pulse on HANGOVER->SILENCE

Behaviour:
- Reset (async assert, sync release): energy=0, energy_valid=0, speech_active=0, pulses 0, fill counter 0, state WARMUP.
- Magnitude: |x| computed at DATA_W+1 bits unsigned. |-32768|=32768, no saturation.
- Accumulate, cycle N with sample_valid=1: at edge N+1, energy <= energy + |data_in| - sub.
  - sub = |data_delayed| once fill counter == WINDOW; otherwise sub = 0.
  - Upstream delay-line contents are undefined until filled, so they are never used before then.
- Fill counter: increments per strobe, saturates at WINDOW. energy_valid rises at the same edge as the WINDOW-th accumulation.
- Internal upd strobe: registered copy of sample_valid, aligned with new energy. FSM acts only on cycles with upd=1 and energy_valid=1.
- No sample_valid means energy and FSM hold.
- FSM (state update one edge after energy update, i.e. 2 cycles after sample_valid):
  - WARMUP -> SILENCE when energy_valid=1.
  - SILENCE: energy > threshold increments onset counter, else clears it. When the counter reaches ONSET_CNT: -> SPEECH, speech_start=1 for one cycle, counter clears.
  - SPEECH: energy <= thr_hold -> HANGOVER, hang counter=1.
  - HANGOVER: energy > thr_hold -> SPEECH, no pulse, counter clears. Else increment; at HANG_CNT -> SILENCE, speech_end=1 for one cycle.
- thr_hold = threshold (without macro).
- Comparisons are unsigned, strict greater-than for on/stay.
- Threshold changes take effect at the next upd.
- speech_active is a registered decode of state; it changes in the same cycle as the pulses.
- Reset mid-operation: everything clears; warm-up restarts and needs a full WINDOW of strobes before any decision.

Optional Feature:
VAD_HYSTERESIS_EN:
- Defined: thr_hold = threshold_low. Integrator guarantees threshold_low <= threshold; behaviour is undefined otherwise.
- Not defined: threshold_low is ignored, thr_hold = threshold, and the port remains for pin compatibility.

Decomposition:
- Package vad_pkg: state enum (WARMUP, SILENCE, SPEECH, HANGOVER; 2-bit encoding), clog2 function, SUM_W legality check constant.
- Sub-module window_accumulator:
  - Contains the abs units, fill counter, energy register, energy_valid and upd.
  - FSM and counters stay in the top.

Test Plan:
Bench overrides: WINDOW=16, ONSET_CNT=2, HANG_CNT=4, SUM_W=24; reference model supplies data_delayed.
- Constant data_in=100 on every strobe, 16 strobes -> energy=1600, energy_valid rises with the 16th update; energy holds 1600 thereafter.
- Constant data_in=-32768 for 20 strobes -> energy=524288 after strobe 16 and steady; no overflow.
- threshold=1000, amplitude stepped from 0 to 200 after fill -> speech_start pulses exactly on the 2nd update with energy>1000; speech_active=1.
- Then amplitude 0 -> HANGOVER. After 4 below-threshold updates, speech_end pulses and speech_active=0. Repeat with a burst on update 3 of hangover -> back to SPEECH, no speech_start.
- Hysteresis (macro on), threshold=1000, threshold_low=400, energy settled at 600 -> stays SPEECH. Macro off -> releases after 4 updates.
- reset_n pulsed low mid-SPEECH, asynchronous to clock -> all outputs 0 immediately. energy_valid stays 0 for the next 15 strobes and rises on the 16th.
